// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared types and sizes for the mem port arbiter
package mem_arbiter_pkg;

   localparam int MEM_AW = 5;
   localparam int MEM_DW = 8;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_ISSUE = 2'd1,
      ARB_RESP  = 2'd2
   } arb_state_t;

   typedef enum logic {
      REQ_CPU = 1'b0,
      REQ_DBG = 1'b1
   } requester_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester, mem and status signals of the mem port arbiter
interface mem_arbiter_if
   import mem_arbiter_pkg::*;
#(
   parameter int AW = MEM_AW,
   parameter int DW = MEM_DW
);
   // CPU requester
   logic          cpu_req;
   logic          cpu_we;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata;
   logic          cpu_ack;
   logic [DW-1:0] cpu_rdata;
   logic          cpu_err;

   // debug / program-loader requester
   logic          dbg_req;
   logic          dbg_we;
   logic [AW-1:0] dbg_addr;
   logic [DW-1:0] dbg_wdata;
   logic          dbg_ack;
   logic [DW-1:0] dbg_rdata;

   // mem instance side
   logic          mem_read;
   logic          mem_write;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   // status
   logic          busy;
   logic          owner;

   // arbiter side
   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_ack, cpu_rdata, cpu_err,
      input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
      output dbg_ack, dbg_rdata,
      output mem_read, mem_write, mem_addr, mem_wdata,
      input  mem_rdata,
      output busy, owner
   );

   // requesters and mem side
   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_ack, cpu_rdata, cpu_err,
      output dbg_req, dbg_we, dbg_addr, dbg_wdata,
      input  dbg_ack, dbg_rdata,
      input  mem_read, mem_write, mem_addr, mem_wdata,
      output mem_rdata,
      input  busy, owner
   );

endinterface

// File: rtl/mem_arbiter_rr_pick.sv
// rtl/mem_arbiter_rr_pick.sv - combinational two-way round-robin chooser
module rr_pick
   import mem_arbiter_pkg::*;
(
   input  logic       cpu_req,
   input  logic       dbg_req,
   input  requester_t owner,
   output logic       grant_valid,
   output requester_t grant_id
);

   // a lone requester always wins; on contention the one that did not go last wins
   always_comb begin
      grant_valid = cpu_req | dbg_req;
      grant_id    = REQ_CPU;
      if (cpu_req && dbg_req) begin
         grant_id = (owner == REQ_CPU) ? REQ_DBG : REQ_CPU;
      end else if (dbg_req) begin
         grant_id = REQ_DBG;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin CPU/DBG sharing of the mem port; optional MEM_ARB_WPROT_EN write protect
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int AW         = MEM_AW,
   parameter int DW         = MEM_DW,
   parameter int PROT_LIMIT = 8
) (
   input  logic          clk,
   input  logic          rst_,
   mem_arbiter_if.slave  bus
);

`ifdef MEM_ARB_WPROT_EN
   localparam bit WPROT_EN = 1'b1;
`else
   localparam bit WPROT_EN = 1'b0;
`endif

   arb_state_t    state_q, state_d;
   requester_t    owner_q, owner_d;
   logic          mem_read_q, mem_read_d;
   logic          mem_write_q, mem_write_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic          cpu_ack_q, cpu_ack_d;
   logic          dbg_ack_q, dbg_ack_d;
   logic          cpu_err_q, cpu_err_d;
   logic          busy_q, busy_d;
   logic          blocked_q, blocked_d;

   logic          grant_valid;
   requester_t    grant_id;
   logic          cpu_blocked;
   logic          win_we;
   logic          win_blk;
   logic [AW-1:0] win_addr;
   logic [DW-1:0] win_wdata;

   rr_pick u_rr_pick (
      .cpu_req     (bus.cpu_req),
      .dbg_req     (bus.dbg_req),
      .owner       (owner_q),
      .grant_valid (grant_valid),
      .grant_id    (grant_id)
   );

   // low-address CPU writes are refused when protection is built in; folds to 0 otherwise
   assign cpu_blocked = WPROT_EN && bus.cpu_we && (int'(bus.cpu_addr) < PROT_LIMIT);

   assign win_we    = (grant_id == REQ_DBG) ? bus.dbg_we    : bus.cpu_we;
   assign win_addr  = (grant_id == REQ_DBG) ? bus.dbg_addr  : bus.cpu_addr;
   assign win_wdata = (grant_id == REQ_DBG) ? bus.dbg_wdata : bus.cpu_wdata;
   assign win_blk   = (grant_id == REQ_CPU) && cpu_blocked;

   // next state and registered outputs: grant in IDLE, drive mem in ISSUE, ack in RESP
   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      blocked_d   = blocked_q;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
      cpu_ack_d   = 1'b0;
      dbg_ack_d   = 1'b0;
      cpu_err_d   = 1'b0;
      busy_d      = 1'b0;
      case (state_q)
         ARB_IDLE: begin
            if (grant_valid) begin
               owner_d     = grant_id;
               addr_d      = win_addr;
               wdata_d     = win_wdata;
               blocked_d   = win_blk;
               mem_write_d = win_we & ~win_blk;
               mem_read_d  = ~win_we;
               busy_d      = 1'b1;
               state_d     = ARB_ISSUE;
            end
         end
         ARB_ISSUE: begin
            cpu_ack_d = (owner_q == REQ_CPU);
            dbg_ack_d = (owner_q == REQ_DBG);
            cpu_err_d = (owner_q == REQ_CPU) & blocked_q;
            busy_d    = 1'b1;
            state_d   = ARB_RESP;
         end
         ARB_RESP: begin
            state_d = ARB_IDLE;
         end
         default: begin
            state_d = ARB_IDLE;
         end
      endcase
   end

   // state and output registers; reset leaves DBG as last owner so the CPU wins first
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state_q     <= ARB_IDLE;
         owner_q     <= REQ_DBG;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         cpu_ack_q   <= 1'b0;
         dbg_ack_q   <= 1'b0;
         cpu_err_q   <= 1'b0;
         busy_q      <= 1'b0;
         blocked_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         mem_read_q  <= mem_read_d;
         mem_write_q <= mem_write_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         cpu_ack_q   <= cpu_ack_d;
         dbg_ack_q   <= dbg_ack_d;
         cpu_err_q   <= cpu_err_d;
         busy_q      <= busy_d;
         blocked_q   <= blocked_d;
      end
   end

   assign bus.mem_read  = mem_read_q;
   assign bus.mem_write = mem_write_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign bus.cpu_ack   = cpu_ack_q;
   assign bus.dbg_ack   = dbg_ack_q;
   assign bus.cpu_err   = cpu_err_q;
   assign bus.busy      = busy_q;
   assign bus.owner     = owner_q;
   // mem registers its output, so read data is already valid in the ack cycle
   assign bus.cpu_rdata = bus.mem_rdata;
   assign bus.dbg_rdata = bus.mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter (optionally with MEM_ARB_WPROT_EN)
module tb_mem_arbiter;
   import mem_arbiter_pkg::*;

   logic clk = 1'b0;
   logic rst_ = 1'b0;
   always #5 clk = ~clk;

   mem_arbiter_if bus ();

   mem_arbiter #(.AW(5), .DW(8), .PROT_LIMIT(8)) dut (
      .clk  (clk),
      .rst_ (rst_),
      .bus  (bus)
   );

   int total = 0;
   int bad = 0;
   int rd_cyc = 0;
   int wr_cyc = 0;
   int cpu_acks = 0;
   int dbg_acks = 0;

   logic [7:0] mem [32];
   logic [7:0] ref_mem [32];
   bit         ref_last;

   // 32x8 mem: registered read port, write on the edge that samples mem_write
   always @(posedge clk) begin
      if (!rst_) begin
         for (int i = 0; i < 32; i++) mem[i] <= 8'hA2 + 8'(i);
      end else begin
         if (bus.mem_read) bus.mem_rdata <= mem[bus.mem_addr];
         if (bus.mem_write) mem[bus.mem_addr] <= bus.mem_wdata;
      end
   end

   // continuous protocol invariants and activity counters
   always @(negedge clk) begin
      if (rst_) begin
         total++;
         if (bus.mem_read && bus.mem_write) begin
            bad++;
            $display("FAIL rw_exclusive got read=%0b write=%0b exp not both", bus.mem_read, bus.mem_write);
         end
         total++;
         if (bus.cpu_ack && bus.dbg_ack) begin
            bad++;
            $display("FAIL ack_exclusive got cpu_ack=1 dbg_ack=1 exp at most one");
         end
         total++;
         if (bus.cpu_err && !bus.cpu_ack) begin
            bad++;
            $display("FAIL err_with_ack got cpu_err=1 cpu_ack=0 exp err only with ack");
         end
         rd_cyc   += int'(bus.mem_read);
         wr_cyc   += int'(bus.mem_write);
         cpu_acks += int'(bus.cpu_ack);
         dbg_acks += int'(bus.dbg_ack);
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "watchdog");
   end

   function automatic void ref_reset();
      for (int i = 0; i < 32; i++) ref_mem[i] = 8'hA2 + 8'(i);
      ref_last = 1'b1;
   endfunction

   function automatic bit ref_blocked(bit who, bit we, logic [4:0] a);
`ifdef MEM_ARB_WPROT_EN
      return (who == 1'b0) && we && (a < 5'd8);
`else
      return 1'b0;
`endif
   endfunction

   task automatic drive_req(bit who, bit we, logic [4:0] a, logic [7:0] d);
      if (who) begin
         bus.dbg_req = 1'b1; bus.dbg_we = we; bus.dbg_addr = a; bus.dbg_wdata = d;
      end else begin
         bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
      end
   endtask

   task automatic drop_req(bit who);
      if (who) bus.dbg_req = 1'b0;
      else bus.cpu_req = 1'b0;
   endtask

   task automatic idle(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic access(input bit who, input bit we, input logic [4:0] a, input logic [7:0] d,
                         output logic [7:0] rd, output bit er, output int cyc);
      drive_req(who, we, a, d);
      cyc = 0;
      do begin
         @(posedge clk); #1; cyc++;
      end while (!(who ? bus.dbg_ack : bus.cpu_ack) && cyc < 20);
      rd = who ? bus.dbg_rdata : bus.cpu_rdata;
      er = bus.cpu_err;
      drop_req(who);
   endtask

   task automatic apply_reset();
      rst_ = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      ref_reset();
      rst_ = 1'b1;
   endtask

   task automatic test_reset();
      drop_req(0); drop_req(1);
      rst_ = 1'b0;
      @(posedge clk); #1;
      total++;
      if ({bus.mem_read, bus.mem_write, bus.cpu_ack, bus.dbg_ack, bus.cpu_err, bus.busy} !== 6'b0) begin
         bad++;
         $display("FAIL reset_ctrl got %b exp 000000",
                  {bus.mem_read, bus.mem_write, bus.cpu_ack, bus.dbg_ack, bus.cpu_err, bus.busy});
      end
      total++;
      if ({bus.mem_addr, bus.mem_wdata} !== 13'h0) begin
         bad++;
         $display("FAIL reset_addr got addr=%0h wdata=%0h exp 0", bus.mem_addr, bus.mem_wdata);
      end
      total++;
      if (bus.owner !== 1'b1) begin
         bad++;
         $display("FAIL reset_owner got %0b exp 1", bus.owner);
      end
      apply_reset();
   endtask

   task automatic test_single_read();
      logic [7:0] rd; bit er; int cyc; int r0, d0;
      r0 = rd_cyc; d0 = dbg_acks;
      access(0, 0, 5'h03, 8'h00, rd, er, cyc);
      total++;
      if (cyc !== 2) begin bad++; $display("FAIL read_latency got %0d exp 2", cyc); end
      total++;
      if (rd !== 8'hA5 || rd !== ref_mem[3]) begin bad++; $display("FAIL read_data got %0h exp %0h", rd, ref_mem[3]); end
      total++;
      if (rd_cyc - r0 !== 1) begin bad++; $display("FAIL read_pulse got %0d exp 1", rd_cyc - r0); end
      total++;
      if (dbg_acks - d0 !== 0) begin bad++; $display("FAIL read_no_dbg_ack got %0d exp 0", dbg_acks - d0); end
      total++;
      if (bus.owner !== 1'b0 || bus.busy !== 1'b1) begin
         bad++; $display("FAIL read_status got owner=%0b busy=%0b exp owner=0 busy=1", bus.owner, bus.busy);
      end
      idle(1);
      total++;
      if (bus.busy !== 1'b0 || bus.cpu_ack !== 1'b0) begin
         bad++; $display("FAIL read_release got busy=%0b ack=%0b exp 0 0", bus.busy, bus.cpu_ack);
      end
   endtask

   task automatic test_dbg_write_cpu_read();
      logic [7:0] rd; bit er; int cyc; int w0;
      w0 = wr_cyc;
      access(1, 1, 5'h10, 8'h3C, rd, er, cyc);
      ref_mem[16] = 8'h3C;
      total++;
      if (cyc !== 2 || er !== 1'b0) begin bad++; $display("FAIL dbg_write_ack got cyc=%0d err=%0b exp 2 0", cyc, er); end
      total++;
      if (wr_cyc - w0 !== 1) begin bad++; $display("FAIL dbg_write_pulse got %0d exp 1", wr_cyc - w0); end
      idle(1);
      access(0, 0, 5'h10, 8'h00, rd, er, cyc);
      total++;
      if (rd !== ref_mem[16]) begin bad++; $display("FAIL readback got %0h exp %0h", rd, ref_mem[16]); end
      idle(1);
   endtask

   task automatic test_back_to_back();
      logic [4:0] a; int cyc, last, n, d0;
      d0 = dbg_acks;
      a = 5'($urandom_range(0, 31));
      drive_req(0, 0, a, 8'h00);
      cyc = 0; last = 0; n = 0;
      while (n < 6 && cyc < 100) begin
         @(posedge clk); #1; cyc++;
         if (bus.cpu_ack) begin
            total++;
            if (bus.cpu_rdata !== ref_mem[a]) begin
               bad++; $display("FAIL b2b_data got %0h exp %0h", bus.cpu_rdata, ref_mem[a]);
            end
            total++;
            if (cyc - last !== ((n == 0) ? 2 : 3)) begin
               bad++; $display("FAIL b2b_spacing got %0d exp %0d", cyc - last, (n == 0) ? 2 : 3);
            end
            last = cyc; n++;
            a = 5'($urandom_range(0, 31));
            drive_req(0, 0, a, 8'h00);
         end
      end
      drop_req(0);
      total++;
      if (n !== 6) begin bad++; $display("FAIL b2b_count got %0d exp 6", n); end
      total++;
      if (dbg_acks - d0 !== 0) begin bad++; $display("FAIL b2b_no_dbg got %0d exp 0", dbg_acks - d0); end
      idle(2);
   endtask

   task automatic test_contention();
      bit         cwe [2];
      logic [4:0] ca  [2];
      logic [7:0] cd  [2];
      int cyc, last, n, errs;
      bit who, exp_who, exp_err;
      rst_ = 1'b0;
      for (int k = 0; k < 2; k++) begin
         cwe[k] = 1'($urandom_range(0, 1));
         ca[k]  = 5'($urandom_range(0, 31));
         cd[k]  = 8'($urandom);
         drive_req(k[0], cwe[k], ca[k], cd[k]);
      end
      apply_reset();
      cyc = 0; last = 0; n = 0;
      while (n < 24 && cyc < 300) begin
         @(posedge clk); #1; cyc++;
         if (bus.cpu_ack || bus.dbg_ack) begin
            who = bus.dbg_ack;
            exp_who = ~ref_last;
            total++;
            if (who !== exp_who) begin bad++; $display("FAIL rr_order got %0b exp %0b at %0d", who, exp_who, n); end
            ref_last = exp_who;
            total++;
            if (bus.owner !== exp_who) begin bad++; $display("FAIL rr_owner got %0b exp %0b", bus.owner, exp_who); end
            total++;
            if (cyc - last !== ((n == 0) ? 2 : 3)) begin
               bad++; $display("FAIL rr_spacing got %0d exp %0d", cyc - last, (n == 0) ? 2 : 3);
            end
            exp_err = ref_blocked(who, cwe[who], ca[who]);
            if (!cwe[who]) begin
               total++;
               if ((who ? bus.dbg_rdata : bus.cpu_rdata) !== ref_mem[ca[who]]) begin
                  bad++; $display("FAIL rr_rdata got %0h exp %0h", who ? bus.dbg_rdata : bus.cpu_rdata, ref_mem[ca[who]]);
               end
            end else if (!exp_err) begin
               ref_mem[ca[who]] = cd[who];
            end
            total++;
            if (bus.cpu_err !== exp_err) begin bad++; $display("FAIL rr_err got %0b exp %0b", bus.cpu_err, exp_err); end
            last = cyc; n++;
            cwe[who] = 1'($urandom_range(0, 1));
            ca[who]  = 5'($urandom_range(0, 31));
            cd[who]  = 8'($urandom);
            drive_req(who, cwe[who], ca[who], cd[who]);
         end
      end
      drop_req(0); drop_req(1);
      total++;
      if (n !== 24) begin bad++; $display("FAIL rr_count got %0d exp 24", n); end
      idle(4);
      errs = 0;
      for (int i = 0; i < 32; i++) if (mem[i] !== ref_mem[i]) errs++;
      total++;
      if (errs !== 0) begin bad++; $display("FAIL rr_mem_image got %0d differing entries exp 0", errs); end
   endtask

   task automatic test_reset_mid();
      int cyc, a0;
      drive_req(0, 0, 5'h05, 8'h00);
      @(posedge clk); #1;
      total++;
      if (bus.mem_read !== 1'b1 || bus.busy !== 1'b1) begin
         bad++; $display("FAIL mid_issue got read=%0b busy=%0b exp 1 1", bus.mem_read, bus.busy);
      end
      drive_req(1, 0, 5'h06, 8'h00);
      rst_ = 1'b0;
      #1;
      total++;
      if ({bus.mem_read, bus.mem_write, bus.cpu_ack, bus.dbg_ack, bus.cpu_err, bus.busy} !== 6'b0 ||
          bus.owner !== 1'b1) begin
         bad++; $display("FAIL mid_reset_outputs got %b owner=%0b exp 000000 owner=1",
                         {bus.mem_read, bus.mem_write, bus.cpu_ack, bus.dbg_ack, bus.cpu_err, bus.busy}, bus.owner);
      end
      a0 = cpu_acks;
      @(posedge clk); #1;
      ref_reset();
      rst_ = 1'b1;
      cyc = 0;
      do begin
         @(posedge clk); #1; cyc++;
      end while (!(bus.cpu_ack || bus.dbg_ack) && cyc < 20);
      total++;
      if (bus.cpu_ack !== 1'b1 || cyc !== 2) begin
         bad++; $display("FAIL mid_first_grant got cpu_ack=%0b cyc=%0d exp 1 2", bus.cpu_ack, cyc);
      end
      total++;
      if (cpu_acks - a0 !== 0 || bus.cpu_rdata !== ref_mem[5]) begin
         bad++; $display("FAIL mid_no_stale_ack got prior_acks=%0d rdata=%0h exp 0 %0h", cpu_acks - a0, bus.cpu_rdata, ref_mem[5]);
      end
      drop_req(0); drop_req(1);
      ref_last = 1'b0;
      idle(3);
   endtask

   task automatic test_wprot();
      logic [7:0] rd; bit er, exp_err; int cyc, w0;
      w0 = wr_cyc;
      exp_err = ref_blocked(0, 1, 5'h02);
      access(0, 1, 5'h02, 8'hFF, rd, er, cyc);
      if (!exp_err) ref_mem[2] = 8'hFF;
      total++;
      if (er !== exp_err || cyc !== 2) begin bad++; $display("FAIL wprot_cpu_err got %0b cyc=%0d exp %0b 2", er, cyc, exp_err); end
      total++;
      if (wr_cyc - w0 !== int'(!exp_err)) begin bad++; $display("FAIL wprot_cpu_pulse got %0d exp %0d", wr_cyc - w0, int'(!exp_err)); end
      total++;
      if (mem[2] !== ref_mem[2]) begin bad++; $display("FAIL wprot_cpu_mem got %0h exp %0h", mem[2], ref_mem[2]); end
      idle(1);
      w0 = wr_cyc;
      access(1, 1, 5'h02, 8'h5A, rd, er, cyc);
      ref_mem[2] = 8'h5A;
      total++;
      if (er !== 1'b0 || wr_cyc - w0 !== 1) begin bad++; $display("FAIL wprot_dbg got err=%0b pulses=%0d exp 0 1", er, wr_cyc - w0); end
      total++;
      if (mem[2] !== ref_mem[2]) begin bad++; $display("FAIL wprot_dbg_mem got %0h exp %0h", mem[2], ref_mem[2]); end
      idle(1);
   endtask

   initial begin
      bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
      bus.dbg_req = 1'b0; bus.dbg_we = 1'b0; bus.dbg_addr = '0; bus.dbg_wdata = '0;
      test_reset();
      test_single_read();
      test_dbg_write_cpu_read();
      test_back_to_back();
      test_contention();
      test_reset_mid();
      test_wprot();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
